mem_wb_stage: RTL and testbench

- MEM/WB pipeline register plus writeback formatting for the 5-stage MIPS32 core.
- Captures MEM-stage results, extracts and extends load data from the synchronous data RAM, and drives the register file write port (we/waddr/wdata) in the WB cycle.
- Obeys the core's 6-bit stall vector and the flush line.
- Keeps a retired-instruction counter.

---
 rtl/mem_wb_stage_pkg.sv | 32 +++
 rtl/mem_wb_stage_load_align.sv | 56 +++++
 rtl/mem_wb_stage.sv | 123 ++++++++++++
 tb/tb_mem_wb_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: bus widths, load-type codes,
// reset/stall encodings and a small load-type classifier.
package mem_wb_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    localparam logic RstEnable = 1'b0;
    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;

    // Codes 6-7 are reserved and fall through to "no load".
    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5
    } ld_type_e;

    // True when the load-type field selects RAM data rather than the ALU result.
    function automatic logic is_load(input logic [2:0] t);
        case (t)
            LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Big-endian load extraction and alignment check. Purely combinational so
// it can be shared by a future unaligned-load unit.
module mem_wb_stage_load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = RegBus
) (
    input  logic [2:0]        ld_type,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] data,
    output logic              misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte/halfword; byte offset 0 is the MSB lane.
    always_comb begin
        byte_sel = rdata[DATA_W-1 -: 8];
        case (addr_lo)
            2'd0:    byte_sel = rdata[DATA_W-1  -: 8];
            2'd1:    byte_sel = rdata[DATA_W-9  -: 8];
            2'd2:    byte_sel = rdata[DATA_W-17 -: 8];
            default: byte_sel = rdata[DATA_W-25 -: 8];
        endcase
        half_sel = addr_lo[1] ? rdata[DATA_W-17 -: 16] : rdata[DATA_W-1 -: 16];
    end

    // Extend the selected lane and flag halfword/word accesses off their boundary.
    always_comb begin
        data     = '0;
        misalign = 1'b0;
        case (ld_type)
            LD_LB:  data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_LBU: data = {{(DATA_W-8){1'b0}}, byte_sel};
            LD_LH: begin
                data     = {{(DATA_W-16){half_sel[15]}}, half_sel};
                misalign = addr_lo[0];
            end
            LD_LHU: begin
                data     = {{(DATA_W-16){1'b0}}, half_sel};
                misalign = addr_lo[0];
            end
            LD_LW: begin
                data     = rdata;
                misalign = (addr_lo != 2'd0);
            end
            default: begin
                data     = '0;
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback formatting and a retired-instruction
// counter. Define MEM_WB_HILO_EN to carry HI/LO write results through the stage.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int REG_AW = RegAddrBus,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_wreg,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [2:0]        mem_ld_type,
    input  logic [1:0]        mem_addr_lo,
    input  logic [DATA_W-1:0] ram_rdata,
`ifdef MEM_WB_HILO_EN
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
`endif
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_valid,
    output logic              wb_misalign,
    output logic [CNT_W-1:0]  retired_cnt
);

    logic              valid_q;
    logic              wreg_q;
    logic [REG_AW-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        ld_q;
    logic [1:0]        addr_q;

    logic              do_clear;
    logic              do_capture;
    logic [DATA_W-1:0] ld_data;
    logic              ld_misalign;
    logic              unused_stall;

    // Only the MEM and WB stall bits matter here.
    assign unused_stall = ^stall[3:0];

    // Flush, or MEM stalled while WB advances, pushes a bubble into WB.
    assign do_clear   = flush | (stall[4] == Stop && stall[5] == NoStop);
    assign do_capture = (stall[4] == NoStop);

    // Pipeline register: reset/bubble clears, MEM advance captures, else hold.
    always_ff @(posedge clk) begin
        if (rst == RstEnable || do_clear) begin
            valid_q <= 1'b0;
            wreg_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= ZeroWord[DATA_W-1:0];
            ld_q    <= LD_NONE;
            addr_q  <= 2'd0;
        end else if (do_capture) begin
            valid_q <= mem_valid;
            wreg_q  <= mem_wreg;
            waddr_q <= mem_waddr;
            wdata_q <= mem_wdata;
            ld_q    <= mem_ld_type;
            addr_q  <= mem_addr_lo;
        end
    end

`ifdef MEM_WB_HILO_EN
    logic              whilo_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    // HI/LO results follow exactly the same advance/bubble/hold rules.
    always_ff @(posedge clk) begin
        if (rst == RstEnable || do_clear) begin
            whilo_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (do_capture) begin
            whilo_q <= mem_whilo;
            hi_q    <= mem_hi;
            lo_q    <= mem_lo;
        end
    end

    assign wb_whilo = valid_q & whilo_q;
    assign wb_hi    = hi_q;
    assign wb_lo    = lo_q;
`endif

    // Count each WB instruction once, on the edge it leaves the stage.
    // A flush only kills the incoming MEM result, so it does not block this.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            retired_cnt <= '0;
        end else if (valid_q && stall[5] == NoStop) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    mem_wb_stage_load_align #(.DATA_W(DATA_W)) u_load_align (
        .ld_type  (ld_q),
        .addr_lo  (addr_q),
        .rdata    (ram_rdata),
        .data     (ld_data),
        .misalign (ld_misalign)
    );

    assign wb_valid    = valid_q;
    assign wb_misalign = valid_q & ld_misalign;
    assign wb_waddr    = waddr_q;
    assign wb_wdata    = is_load(ld_q) ? ld_data : wdata_q;
    assign wb_we       = valid_q & wreg_q & ~wb_misalign;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, ALU pass-through, load extraction,
// misalignment, stall hold/bubble, flush and counter behaviour.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_wreg;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ld_type;
    logic [1:0]  mem_addr_lo;
    logic [31:0] ram_rdata;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_valid;
    logic        wb_misalign;
    logic [31:0] retired_cnt;
`ifdef MEM_WB_HILO_EN
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .mem_valid   (mem_valid),
        .mem_wreg    (mem_wreg),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_ld_type (mem_ld_type),
        .mem_addr_lo (mem_addr_lo),
        .ram_rdata   (ram_rdata),
`ifdef MEM_WB_HILO_EN
        .mem_whilo   (mem_whilo),
        .mem_hi      (mem_hi),
        .mem_lo      (mem_lo),
        .wb_whilo    (wb_whilo),
        .wb_hi       (wb_hi),
        .wb_lo       (wb_lo),
`endif
        .wb_we       (wb_we),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .wb_valid    (wb_valid),
        .wb_misalign (wb_misalign),
        .retired_cnt (retired_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic [2:0] t, input logic [1:0] lo);
        mem_valid   = v;
        mem_wreg    = w;
        mem_waddr   = a;
        mem_wdata   = d;
        mem_ld_type = t;
        mem_addr_lo = lo;
    endtask

    // Issue one load into WB; the previous WB entry (always valid here) retires.
    task automatic ld_vec(input string tag, input logic [2:0] t, input logic [1:0] lo,
                          input logic [31:0] exp_data, input logic mis);
        drive(1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, t, lo);
        cyc();
        exp_cnt++;
        chk({tag, "_mis"}, {31'd0, wb_misalign}, {31'd0, mis});
        chk({tag, "_we"},  {31'd0, wb_we},       {31'd0, ~mis});
        if (!mis) chk({tag, "_data"}, wb_wdata, exp_data);
    endtask

    initial begin
        rst = 1'b0; stall = 6'd0; flush = 1'b0; ram_rdata = 32'h0;
`ifdef MEM_WB_HILO_EN
        mem_whilo = 1'b0; mem_hi = 32'h0; mem_lo = 32'h0;
`endif
        drive(1'b1, 1'b1, 5'd3, 32'hAAAA_AAAA, 3'd0, 2'd0);
        cyc();
        cyc();
        chk("rst_we",    {31'd0, wb_we},    32'd0);
        chk("rst_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wdata", wb_wdata,          32'd0);
        chk("rst_waddr", {27'd0, wb_waddr}, 32'd0);
        chk("rst_cnt",   retired_cnt,       32'd0);

        // ALU pass-through
        rst = 1'b1;
        drive(1'b1, 1'b1, 5'd5, 32'h1234_5678, 3'd0, 2'd0);
        cyc();
        chk("alu_we",    {31'd0, wb_we},    32'd1);
        chk("alu_waddr", {27'd0, wb_waddr}, 32'd5);
        chk("alu_wdata", wb_wdata,          32'h1234_5678);
        chk("alu_cnt0",  retired_cnt,       32'd0);

        // Loads against a fixed RAM word
        ram_rdata = 32'h80FF_7F01;
        ld_vec("lb0",   3'd1, 2'd0, 32'hFFFF_FF80, 1'b0);
        chk("alu_cnt1", retired_cnt, 32'd1);
        ld_vec("lbu1",  3'd2, 2'd1, 32'h0000_00FF, 1'b0);
        ld_vec("lh2",   3'd3, 2'd2, 32'h0000_7F01, 1'b0);
        ld_vec("lhu0",  3'd4, 2'd0, 32'h0000_80FF, 1'b0);
        ld_vec("lh0",   3'd3, 2'd0, 32'hFFFF_80FF, 1'b0);
        ld_vec("lb3",   3'd1, 2'd3, 32'h0000_0001, 1'b0);
        ld_vec("lbu2",  3'd2, 2'd2, 32'h0000_007F, 1'b0);
        ld_vec("lw0",   3'd5, 2'd0, 32'h80FF_7F01, 1'b0);
        ld_vec("lw2",   3'd5, 2'd2, 32'h0,         1'b1);
        ld_vec("lh1",   3'd3, 2'd1, 32'h0,         1'b1);
        ld_vec("lhu3",  3'd4, 2'd3, 32'h0,         1'b1);
        chk("load_cnt", retired_cnt, exp_cnt);

        // Reserved load type behaves as a plain ALU write
        drive(1'b1, 1'b1, 5'd4, 32'hCAFE_F00D, 3'd7, 2'd2);
        cyc();
        exp_cnt++;
        chk("rsv_data", wb_wdata,           32'hCAFE_F00D);
        chk("rsv_mis",  {31'd0, wb_misalign}, 32'd0);

        // Hold: both MEM and WB stalled
        drive(1'b1, 1'b1, 5'd9, 32'h1111_2222, 3'd0, 2'd0);
        cyc();
        exp_cnt++;
        chk("pre_hold_waddr", {27'd0, wb_waddr}, 32'd9);
        stall = 6'b111111;
        drive(1'b1, 1'b1, 5'd10, 32'h3333_3333, 3'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_waddr", {27'd0, wb_waddr}, 32'd9);
            chk("hold_wdata", wb_wdata,          32'h1111_2222);
            chk("hold_cnt",   retired_cnt,       exp_cnt);
        end

        // WB released while MEM stalled: held entry retires once, bubble enters
        stall = 6'b011111;
        cyc();
        exp_cnt++;
        chk("bub_valid", {31'd0, wb_valid}, 32'd0);
        chk("bub_we",    {31'd0, wb_we},    32'd0);
        chk("bub_cnt",   retired_cnt,       exp_cnt);
        cyc();
        chk("bub_cnt2",  retired_cnt,       exp_cnt);

        // Flush kills the incoming r7 write
        stall = 6'b000000;
        flush = 1'b1;
        drive(1'b1, 1'b1, 5'd7, 32'h7777_7777, 3'd0, 2'd0);
        cyc();
        chk("fl_valid", {31'd0, wb_valid}, 32'd0);
        chk("fl_we",    {31'd0, wb_we},    32'd0);
        chk("fl_waddr", {27'd0, wb_waddr}, 32'd0);

        // Lower stall bits do not affect this stage
        flush = 1'b0;
        stall = 6'b001111;
        cyc();
        chk("lo_stall_we",    {31'd0, wb_we},    32'd1);
        chk("lo_stall_waddr", {27'd0, wb_waddr}, 32'd7);
        chk("lo_stall_cnt",   retired_cnt,       exp_cnt);

        // Flush does not cancel the retiring WB instruction's count
        stall = 6'b000000;
        flush = 1'b1;
        cyc();
        exp_cnt++;
        chk("fl_cnt", retired_cnt, exp_cnt);
        flush = 1'b0;

        // waddr 0 forwarded unchanged
        drive(1'b1, 1'b1, 5'd0, 32'h0000_00AB, 3'd0, 2'd0);
        cyc();
        chk("r0_waddr", {27'd0, wb_waddr}, 32'd0);
        chk("r0_we",    {31'd0, wb_we},    32'd1);

        // Non-writing instruction
        drive(1'b1, 1'b0, 5'd12, 32'h5, 3'd0, 2'd0);
        cyc();
        chk("nowreg_we",    {31'd0, wb_we},    32'd0);
        chk("nowreg_valid", {31'd0, wb_valid}, 32'd1);

        // Reset overrides stall and flush
        rst = 1'b0;
        stall = 6'b111111;
        flush = 1'b1;
        cyc();
        chk("rst2_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst2_cnt",   retired_cnt,       32'd0);
        chk("rst2_wdata", wb_wdata,          32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
